counter_seq_ctrl: RTL and testbench

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

---
 rtl/counter_seq_ctrl.sv | 111 +++++++++++
 tb/tb_counter_seq_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an external counter datapath: start/pause/resume/clear,
// prescaled count enables and terminal-count handling in one-shot or periodic mode.
module counter_seq_ctrl #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         clear,
    input  logic         mode,
    input  logic [W-1:0] presc,
    input  logic [W-1:0] limit,
    input  logic [W-1:0] cnt_q,
    output logic         cnt_en,
    output logic         cnt_clr,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic         terminal_c;
    logic         en_c, clr_c, done_c;

    // State and prescale registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign terminal_c = (state_q == ST_RUN) && (cnt_q == limit);

    // Next state, prescale update and Mealy strobes; priority clear > terminal > stop > start
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        en_c    = 1'b0;
        clr_c   = 1'b0;
        done_c  = 1'b0;
        if (clear) begin
            clr_c   = 1'b1;
            pc_d    = '0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        clr_c   = 1'b1;
                        pc_d    = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (terminal_c) begin
                        done_c = 1'b1;
                        if (mode) begin
                            clr_c = 1'b1;
                            pc_d  = '0;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else if (stop) begin
                        state_d = ST_PAUSE;
                    end else if (pc_q >= presc) begin
                        en_c = 1'b1;
                        pc_d = '0;
                    end else begin
                        pc_d = pc_q + W'(1);
                    end
                end
                ST_PAUSE: begin
                    // Resume keeps the partial prescale count
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        clr_c   = 1'b1;
                        pc_d    = '0;
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                end
            endcase
        end
    end

    // Strobes are forced low while reset is held so the datapath is never touched by reset
    assign cnt_en  = en_c & reset;
    assign cnt_clr = clr_c & reset;
    assign done    = done_c & reset;
    assign busy    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign state   = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural model of the external counter.
module tb_counter_seq_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset, start, stop, clear, mode;
    logic [W-1:0] presc, limit;
    logic [W-1:0] cnt_q = '0;
    logic         cnt_en, cnt_clr, busy, done;
    logic [1:0]   state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    counter_seq_ctrl #(.W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
        .mode(mode), .presc(presc), .limit(limit), .cnt_q(cnt_q),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .busy(busy), .done(done), .state(state)
    );

    // External counter datapath: no reset, clear wins over enable
    always @(posedge clk) begin
        if (cnt_clr)     cnt_q <= '0;
        else if (cnt_en) cnt_q <= cnt_q + W'(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_cyc(input string tag, input int c, input bit en_e, input bit clr_e,
                           input bit done_e, input logic [1:0] st_e);
        string t;
        t = $sformatf("%s c%0d", tag, c);
        chk({t, " cnt_en"}, 32'(cnt_en), 32'(en_e));
        chk({t, " cnt_clr"}, 32'(cnt_clr), 32'(clr_e));
        chk({t, " done"}, 32'(done), 32'(done_e));
        chk({t, " state"}, 32'(state), 32'(st_e));
        chk({t, " busy"}, 32'(busy), 32'(st_e == 2'b01 || st_e == 2'b10));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        chk("clear strobe", 32'(cnt_clr), 32'd1);
        next_cycle();
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b1; stop = 1'b0; clear = 1'b0;
        mode  = 1'b0; presc = 8'd3; limit = 8'd5;
        #2;
        chk_cyc("in_reset", 0, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("in_reset pc", 32'(dut.pc_q), 32'd0);
        next_cycle();
        chk_cyc("in_reset", 1, 1'b0, 1'b0, 1'b0, 2'b00);
        start = 1'b0;
        #2 reset = 1'b1;
        next_cycle();

        // One-shot, presc=3, limit=5
        for (int c = 0; c <= 23; c++) begin
            start = (c == 0);
            @(negedge clk);
            chk_cyc("oneshot", c, (c >= 4 && c <= 20 && c % 4 == 0), (c == 0), (c == 21),
                    (c == 0) ? 2'b00 : (c <= 21) ? 2'b01 : 2'b11);
            next_cycle();
        end

        // Periodic from DONE; then clear together with stop
        mode = 1'b1;
        for (int c = 0; c <= 44; c++) begin
            start = (c == 0);
            clear = (c == 43);
            stop  = (c == 43);
            @(negedge clk);
            if (c <= 42)
                chk_cyc("periodic", c,
                        (c >= 4 && c <= 20 && c % 4 == 0) || (c >= 25 && c <= 41 && (c - 25) % 4 == 0),
                        (c == 0 || c == 21 || c == 42), (c == 21 || c == 42),
                        (c == 0) ? 2'b11 : 2'b01);
            else if (c == 43)
                chk_cyc("clr+stop", c, 1'b0, 1'b1, 1'b0, 2'b01);
            else begin
                chk_cyc("after_clr", c, 1'b0, 1'b0, 1'b0, 2'b00);
                chk("after_clr pc", 32'(dut.pc_q), 32'd0);
                chk("after_clr cnt", 32'(cnt_q), 32'd0);
            end
            next_cycle();
        end
        clear = 1'b0; stop = 1'b0;

        // Pause/resume, then terminal coinciding with stop in one-shot
        mode = 1'b0;
        for (int c = 0; c <= 27; c++) begin
            start = (c == 0 || c == 10);
            stop  = (c == 6 || c == 26);
            @(negedge clk);
            chk_cyc("pause", c, (c == 4 || c == 13 || c == 17 || c == 21 || c == 25),
                    (c == 0), (c == 26),
                    (c == 0) ? 2'b00 : (c <= 6) ? 2'b01 : (c <= 10) ? 2'b10 :
                    (c <= 26) ? 2'b01 : 2'b11);
            if (c >= 7 && c <= 10) chk($sformatf("pause pc c%0d", c), 32'(dut.pc_q), 32'd1);
            next_cycle();
        end
        start = 1'b0; stop = 1'b0;

        // Asynchronous reset mid-RUN, counter value untouched
        for (int c = 0; c <= 5; c++) begin
            start = (c == 0);
            next_cycle();
        end
        #3;
        reset = 1'b0;
        start = 1'b1;
        #1;
        chk_cyc("async_rst", 0, 1'b0, 1'b0, 1'b0, 2'b00);
        chk("async_rst pc", 32'(dut.pc_q), 32'd0);
        next_cycle();
        chk("async_rst cnt held", 32'(cnt_q), 32'd1);
        start = 1'b0;
        #2 reset = 1'b1;
        next_cycle();
        start = 1'b1;
        @(negedge clk);
        chk_cyc("post_rst", 0, 1'b0, 1'b1, 1'b0, 2'b00);
        next_cycle();
        start = 1'b0;
        @(negedge clk);
        chk_cyc("post_rst", 1, 1'b0, 1'b0, 1'b0, 2'b01);
        chk("post_rst cnt", 32'(cnt_q), 32'd0);
        next_cycle();

        // presc lowered mid-run ticks on that same cycle
        do_clear();
        presc = 8'd10; limit = 8'd200;
        for (int c = 0; c <= 9; c++) begin
            start = (c == 0);
            if (c == 6) presc = 8'd2;
            @(negedge clk);
            chk_cyc("presc_chg", c, (c == 6 || c == 9), (c == 0), 1'b0,
                    (c == 0) ? 2'b00 : 2'b01);
            next_cycle();
        end

        // limit=0 periodic: done every RUN cycle
        do_clear();
        presc = 8'd0; limit = 8'd0; mode = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            start = (c == 0);
            @(negedge clk);
            chk_cyc("lim0_per", c, 1'b0, 1'b1, (c >= 1), (c == 0) ? 2'b00 : 2'b01);
            next_cycle();
        end

        // limit=0 one-shot: DONE after first RUN cycle
        do_clear();
        mode = 1'b0;
        for (int c = 0; c <= 2; c++) begin
            start = (c == 0);
            @(negedge clk);
            chk_cyc("lim0_one", c, 1'b0, (c == 0), (c == 1),
                    (c == 0) ? 2'b00 : (c == 1) ? 2'b01 : 2'b11);
            next_cycle();
        end

        // presc=0: enable every non-terminal RUN cycle
        limit = 8'd3;
        for (int c = 0; c <= 5; c++) begin
            start = (c == 0);
            @(negedge clk);
            chk_cyc("presc0", c, (c >= 1 && c <= 3), (c == 0), (c == 4),
                    (c == 0) ? 2'b11 : (c <= 4) ? 2'b01 : 2'b11);
            next_cycle();
        end
        start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
